// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A interrupt-acknowledge side:
// FSM encoding, default timing constants and the vector width.
package pic_pkg;

    localparam int VEC_W           = 8;
    localparam int DEF_PULSE_W     = 2;
    localparam int DEF_GAP_W       = 2;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PULSE1 = 3'd1,
        GAP    = 3'd2,
        PULSE2 = 3'd3,
        HOLD   = 3'd4
    } inta_state_t;

    // Counter wide enough to hold the larger of the pulse/gap reload values.
    function automatic int cnt_width(input int pulse_w, input int gap_w);
        return $clog2((pulse_w > gap_w) ? pulse_w : gap_w) + 1;
    endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// PIC-facing and core-facing signals of the INTA# sequencer.
// slave = the sequencer itself, master = the PIC/core environment driving it.
interface inta_sequencer_if;
    import pic_pkg::*;

    logic             int_req;
    logic             int_enable;
    logic [VEC_W-1:0] data_in;
    logic             inta_n;
    logic             lock_n;
    logic             busy;
    logic [VEC_W-1:0] vector;
    logic             vector_valid;
    logic             vector_ack;

    modport slave (
        input  int_req, int_enable, data_in, vector_ack,
        output inta_n, lock_n, busy, vector, vector_valid
    );

    modport master (
        output int_req, int_enable, data_in, vector_ack,
        input  inta_n, lock_n, busy, vector, vector_valid
    );

endinterface

// File: rtl/int_synchronizer.sv
// N-flop synchronizer for an asynchronous level; clears to 0 on reset.
module int_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side INTA# two-pulse sequencer for the 8259A: issues the acknowledge
// train, captures the vector on the second pulse and hands it to the core.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int PULSE_W     = DEF_PULSE_W,
    parameter int GAP_W       = DEF_GAP_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    inta_sequencer_if.slave         bus
);

    localparam int CNT_W = cnt_width(PULSE_W, GAP_W);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);

    inta_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             int_sync;

    int_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.int_req),
        .q     (int_sync)
    );

    // Outputs are set on the same edge that enters the state they belong to,
    // so they track the state register exactly while coming straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.inta_n       <= 1'b1;
            bus.lock_n       <= 1'b1;
            bus.vector       <= '0;
            bus.vector_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (int_sync && bus.int_enable) begin
                        state      <= PULSE1;
                        cnt        <= PULSE_LOAD;
                        bus.inta_n <= 1'b0;
                        bus.lock_n <= 1'b0;
                    end
                end
                PULSE1: begin
                    if (cnt == '0) begin
                        state      <= GAP;
                        cnt        <= GAP_LOAD;
                        bus.inta_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state      <= PULSE2;
                        cnt        <= PULSE_LOAD;
                        bus.inta_n <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PULSE2: begin
                    // PIC drives the vector while the second pulse is low.
                    if (cnt == '0) begin
                        state            <= HOLD;
                        bus.vector       <= bus.data_in;
                        bus.vector_valid <= 1'b1;
                        bus.inta_n       <= 1'b1;
                        bus.lock_n       <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.vector_ack) begin
                        state            <= IDLE;
                        bus.vector_valid <= 1'b0;
                    end
                end
                default: begin
                    state            <= IDLE;
                    cnt              <= '0;
                    bus.inta_n       <= 1'b1;
                    bus.lock_n       <= 1'b1;
                    bus.vector_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_inta_sequencer.sv
// Scenario bench for inta_sequencer: PIC-side stimulus with a vector
// scoreboard and cycle-exact INTA#/LOCK# expectations.
module tb_inta_sequencer;

    localparam int PW = 2;
    localparam int GW = 2;
    localparam int SS = 2;
    localparam int LAT = SS + 1;
    localparam int TRAIN = PW + GW + PW;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    inta_sequencer_if bus();

    inta_sequencer #(
        .PULSE_W     (PW),
        .GAP_W       (GW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // k = cycles since the first expected INTA# low cycle
    function automatic logic exp_inta(input int k);
        if (k < 0)            return 1'b1;
        if (k < PW)           return 1'b0;
        if (k < PW + GW)      return 1'b1;
        if (k < TRAIN)        return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_lock(input int k);
        return (k >= 0 && k < TRAIN) ? 1'b0 : 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.vector_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.int_req = 1'b1;
        bus.int_enable = 1'b1;
        bus.data_in = 8'hA5;
        idle(3);
        @(negedge clk);
        checks++; if (bus.inta_n !== 1'b1) begin errors++; $display("FAIL reset_inta_n got=%b exp=1", bus.inta_n); end
        checks++; if (bus.lock_n !== 1'b1) begin errors++; $display("FAIL reset_lock_n got=%b exp=1", bus.lock_n); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.vector !== 8'h00) begin errors++; $display("FAIL reset_vector got=%h exp=00", bus.vector); end
        checks++; if (bus.vector_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.vector_valid); end
        bus.int_req = 1'b0;
        bus.int_enable = 1'b0;
        step();
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_basic();
        bus.int_enable = 1'b1;
        bus.data_in = 8'h4B;
        exp_q.push_back(8'h4B);
        step();
        bus.int_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (bus.inta_n !== exp_inta(k - LAT)) begin errors++; $display("FAIL basic_inta_n cyc=%0d got=%b exp=%b", k, bus.inta_n, exp_inta(k - LAT)); end
            checks++; if (bus.lock_n !== exp_lock(k - LAT)) begin errors++; $display("FAIL basic_lock_n cyc=%0d got=%b exp=%b", k, bus.lock_n, exp_lock(k - LAT)); end
            checks++; if (bus.vector_valid !== (k == 9)) begin errors++; $display("FAIL basic_valid cyc=%0d got=%b exp=%b", k, bus.vector_valid, (k == 9)); end
            if (k == 9) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL basic_vector got=%h exp=<empty scoreboard>", bus.vector); end
                else begin
                    exp_v = exp_q.pop_front();
                    if (bus.vector !== exp_v) begin errors++; $display("FAIL basic_vector got=%h exp=%h", bus.vector, exp_v); end
                end
            end else begin
                step();
            end
        end
        bus.vector_ack = 1'b1;
        bus.int_enable = 1'b0;
        bus.int_req = 1'b0;
        step();
        bus.vector_ack = 1'b0;
        @(negedge clk);
        checks++; if (bus.vector_valid !== 1'b0) begin errors++; $display("FAIL basic_ack_valid got=%b exp=0", bus.vector_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_ack_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.vector !== 8'h4B) begin errors++; $display("FAIL basic_vector_kept got=%h exp=4b", bus.vector); end
        idle(4);
    endtask

    task automatic test_enable_gating();
        bit ok;
        bus.int_enable = 1'b0;
        bus.data_in = 8'h21;
        exp_q.push_back(8'h21);
        bus.int_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            checks++; if (bus.inta_n !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL gate_blocked cyc=%0d inta_n=%b busy=%b exp=1/0", i, bus.inta_n, bus.busy); end
        end
        step();
        bus.int_enable = 1'b1;
        @(negedge clk);
        checks++; if (bus.inta_n !== 1'b1) begin errors++; $display("FAIL gate_same_cycle got=%b exp=1", bus.inta_n); end
        step();
        @(negedge clk);
        checks++; if (bus.inta_n !== 1'b0) begin errors++; $display("FAIL gate_next_cycle got=%b exp=0", bus.inta_n); end
        wait_valid(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL gate_valid_timeout got=0 exp=1"); end
        else if (exp_q.size() == 0) begin errors++; $display("FAIL gate_vector got=%h exp=<empty scoreboard>", bus.vector); end
        else begin
            exp_v = exp_q.pop_front();
            if (bus.vector !== exp_v) begin errors++; $display("FAIL gate_vector got=%h exp=%h", bus.vector, exp_v); end
        end
        bus.vector_ack = 1'b1;
        bus.int_enable = 1'b0;
        bus.int_req = 1'b0;
        step();
        bus.vector_ack = 1'b0;
        idle(4);
    endtask

    task automatic test_withdrawn();
        bit ok;
        bus.int_enable = 1'b1;
        bus.data_in = 8'h47;
        exp_q.push_back(8'h47);
        step();
        bus.int_req = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 5) bus.int_req = 1'b0;
            checks++; if (bus.inta_n !== exp_inta(k - LAT)) begin errors++; $display("FAIL withdraw_inta_n cyc=%0d got=%b exp=%b", k, bus.inta_n, exp_inta(k - LAT)); end
            checks++; if (bus.lock_n !== exp_lock(k - LAT)) begin errors++; $display("FAIL withdraw_lock_n cyc=%0d got=%b exp=%b", k, bus.lock_n, exp_lock(k - LAT)); end
            step();
        end
        wait_valid(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL withdraw_valid_timeout got=0 exp=1"); end
        else if (exp_q.size() == 0) begin errors++; $display("FAIL withdraw_vector got=%h exp=<empty scoreboard>", bus.vector); end
        else begin
            exp_v = exp_q.pop_front();
            if (bus.vector !== exp_v) begin errors++; $display("FAIL withdraw_vector got=%h exp=%h", bus.vector, exp_v); end
        end
        bus.vector_ack = 1'b1;
        step();
        bus.vector_ack = 1'b0;
        bus.int_enable = 1'b0;
        idle(4);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL withdraw_no_restart busy=%b exp=0", bus.busy); end
        step();
    endtask

    task automatic test_back_to_back();
        bit ok;
        bus.int_enable = 1'b1;
        bus.data_in = 8'h5A;
        exp_q.push_back(8'h5A);
        step();
        bus.int_req = 1'b1;
        wait_valid(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_valid1_timeout got=0 exp=1"); end
        else if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_vector1 got=%h exp=<empty scoreboard>", bus.vector); end
        else begin
            exp_v = exp_q.pop_front();
            if (bus.vector !== exp_v) begin errors++; $display("FAIL b2b_vector1 got=%h exp=%h", bus.vector, exp_v); end
        end
        bus.data_in = 8'h66;
        exp_q.push_back(8'h66);
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            checks++; if (bus.inta_n !== 1'b1 || bus.lock_n !== 1'b1) begin errors++; $display("FAIL b2b_hold_quiet cyc=%0d inta_n=%b lock_n=%b exp=1/1", i, bus.inta_n, bus.lock_n); end
            checks++; if (bus.vector_valid !== 1'b1 || bus.vector !== 8'h5A) begin errors++; $display("FAIL b2b_hold_vector cyc=%0d valid=%b vector=%h exp=1/5a", i, bus.vector_valid, bus.vector); end
        end
        bus.vector_ack = 1'b1;
        step();
        bus.vector_ack = 1'b0;
        @(negedge clk);
        checks++; if (bus.vector_valid !== 1'b0 || bus.busy !== 1'b0 || bus.inta_n !== 1'b1) begin errors++; $display("FAIL b2b_idle valid=%b busy=%b inta_n=%b exp=0/0/1", bus.vector_valid, bus.busy, bus.inta_n); end
        step();
        @(negedge clk);
        checks++; if (bus.inta_n !== 1'b0) begin errors++; $display("FAIL b2b_restart got=%b exp=0", bus.inta_n); end
        checks++; if (bus.vector !== 8'h5A) begin errors++; $display("FAIL b2b_vector_early got=%h exp=5a", bus.vector); end
        step();
        wait_valid(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_valid2_timeout got=0 exp=1"); end
        else if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_vector2 got=%h exp=<empty scoreboard>", bus.vector); end
        else begin
            exp_v = exp_q.pop_front();
            if (bus.vector !== exp_v) begin errors++; $display("FAIL b2b_vector2 got=%h exp=%h", bus.vector, exp_v); end
        end
        bus.vector_ack = 1'b1;
        bus.int_enable = 1'b0;
        bus.int_req = 1'b0;
        step();
        bus.vector_ack = 1'b0;
        idle(4);
    endtask

    task automatic test_reset_gap();
        bus.int_enable = 1'b1;
        bus.data_in = 8'h33;
        step();
        bus.int_req = 1'b1;
        idle(5);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.inta_n !== 1'b1 || bus.lock_n !== 1'b0) begin errors++; $display("FAIL rgap_in_gap busy=%b inta_n=%b lock_n=%b exp=1/1/0", bus.busy, bus.inta_n, bus.lock_n); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.inta_n !== 1'b1 || bus.lock_n !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL rgap_async inta_n=%b lock_n=%b busy=%b exp=1/1/0", bus.inta_n, bus.lock_n, bus.busy); end
        checks++; if (bus.vector_valid !== 1'b0 || bus.vector !== 8'h00) begin errors++; $display("FAIL rgap_async_vec valid=%b vector=%h exp=0/00", bus.vector_valid, bus.vector); end
        idle(2);
        rst_n = 1'b1;
        exp_q.push_back(8'h33);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (bus.inta_n !== exp_inta(k - LAT)) begin errors++; $display("FAIL rgap_inta_n cyc=%0d got=%b exp=%b", k, bus.inta_n, exp_inta(k - LAT)); end
            checks++; if (bus.lock_n !== exp_lock(k - LAT)) begin errors++; $display("FAIL rgap_lock_n cyc=%0d got=%b exp=%b", k, bus.lock_n, exp_lock(k - LAT)); end
            checks++; if (bus.vector_valid !== (k == 9)) begin errors++; $display("FAIL rgap_valid cyc=%0d got=%b exp=%b", k, bus.vector_valid, (k == 9)); end
            if (k == 9) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL rgap_vector got=%h exp=<empty scoreboard>", bus.vector); end
                else begin
                    exp_v = exp_q.pop_front();
                    if (bus.vector !== exp_v) begin errors++; $display("FAIL rgap_vector got=%h exp=%h", bus.vector, exp_v); end
                end
            end else begin
                step();
            end
        end
        bus.vector_ack = 1'b1;
        bus.int_enable = 1'b0;
        bus.int_req = 1'b0;
        step();
        bus.vector_ack = 1'b0;
        idle(4);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.int_req = 1'b0;
        bus.int_enable = 1'b0;
        bus.data_in = 8'h00;
        bus.vector_ack = 1'b0;

        test_reset();
        test_basic();
        test_enable_gating();
        test_withdrawn();
        test_back_to_back();
        test_reset_gap();

        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size()); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inta_sequencer.md
# inta_sequencer

CPU-side interrupt acknowledge initiator for the 8259A PIC. It watches the PIC's INT output and drives the two-pulse INTA# bus sequence that the PIC control logic responds to. It captures the interrupt vector the PIC places on the data bus during the second pulse and hands it to the CPU core through a valid/ack handshake. It sits between the PIC instance and the core model in the system testbench/top.

## Interface
Parameters:
- PULSE_W, default 2: INTA# low time per pulse, in clk cycles (≥1).
- GAP_W, default 2: INTA# high time between the two pulses, in clk cycles (≥1).
- SYNC_STAGES, default 2: synchronizer depth for int_req (≥2).

Ports (single clock `clk`; reset `rst_n` is asynchronous, active-low):
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- int_req  in  1  INT from PIC, asynchronous level.
- int_enable  in  1  CPU interrupt-enable flag (IF); synchronous.
- data_in  in  8  data bus from PIC (IV).
- inta_n  out  1  INTA# to PIC, active low, registered.
- lock_n  out  1  bus LOCK#, active low, registered.
- busy  out  1  high whenever the FSM is not in IDLE.
- vector  out  8  captured interrupt vector.
- vector_valid  out  1  vector holds a new, unconsumed value.
- vector_ack  in  1  core consumes the vector.

## Operation
- int_req passes through a SYNC_STAGES flop chain; `int_sync` is the last stage.
- FSM states: IDLE, PULSE1, GAP, PULSE2, HOLD. A single down-counter (width clog2(max(PULSE_W,GAP_W))+1) times PULSE1, GAP and PULSE2.
- IDLE: if int_sync & int_enable, go to PULSE1 and load the counter with PULSE_W-1. Otherwise stay.
- PULSE1: inta_n=0, lock_n=0. When the counter reaches 0, go to GAP and load GAP_W-1.
- GAP: inta_n=1, lock_n=0. When the counter reaches 0, go to PULSE2 and load PULSE_W-1.
- PULSE2: inta_n=0, lock_n=0. On the edge that ends the last PULSE2 cycle (counter 0), register data_in into vector and go to HOLD.
- HOLD: inta_n=1, lock_n=1, vector_valid=1. When vector_ack=1, clear vector_valid and go to IDLE.
- Once PULSE1 starts, the sequence always completes:
  - int_req dropping is ignored (PIC supplies its own spurious vector).
  - int_enable dropping is ignored.
- vector keeps its last value after the ack. It changes only on a PULSE2 capture.
- vector_ack outside HOLD has no effect.
- inta_n, lock_n and vector_valid come directly from flops (glitch-free).

## Timing
- Reset values: inta_n=1, lock_n=1, busy=0, vector=8'h00, vector_valid=0, FSM=IDLE, sync chain=0, counter=0.
- Latency from int_req rising (first sampling edge, cycle 0) to inta_n low: inta_n falls at the start of cycle SYNC_STAGES+1.
- The INTA# train lasts PULSE_W + GAP_W + PULSE_W cycles. lock_n is low for exactly this span.
- vector_valid rises the cycle after the last PULSE2 cycle, with vector already stable.
- An ack in the first HOLD cycle gives IDLE in the next cycle. The minimum IDLE dwell is 1 cycle before a new PULSE1, so back-to-back sequences are separated by at least HOLD+IDLE.
- int_req held high through HOLD does not start a new sequence until IDLE is reached.
- Reset asserted mid-sequence: all outputs return to reset values asynchronously. After release, the FSM starts from IDLE and no partial vector is reported.

## Structure
- Shared package `pic_pkg` holds:
  - the FSM state encoding: `inta_state_t` with IDLE/PULSE1/GAP/PULSE2/HOLD;
  - the default PULSE_W/GAP_W/SYNC_STAGES constants;
  - the `VEC_W=8` width constant.
- One sub-module, `int_synchronizer`: a parameterized N-flop chain with async active-low reset to 0. It is instantiated once for int_req.

## Test plan
1. Reset: hold rst_n=0 with int_req=1 → inta_n=1, lock_n=1, busy=0, vector=8'h00, vector_valid=0.
2. Basic sequence, defaults: int_req=1 and int_enable=1 from cycle 0, data_in=8'h4B during PULSE2.
   - inta_n low in cycles 3–4 and 7–8, high in 5–6.
   - lock_n low in cycles 3–8.
   - vector=8'h4B and vector_valid=1 from cycle 9 until ack.
3. Enable gating: int_req=1, int_enable=0 for 20 cycles → inta_n stays 1. Raise int_enable → inta_n falls 1 cycle after int_enable is sampled high.
4. Request withdrawn: drop int_req during GAP, data_in=8'h47 → second pulse still issued, vector=8'h47.
5. Delayed ack: hold int_req=1 and delay vector_ack by 5 cycles in HOLD → no INTA# activity during HOLD. A new sequence starts 2 cycles after the ack; vector is overwritten only at the new PULSE2.
6. Reset during GAP: assert rst_n=0 mid-GAP → inta_n=1, lock_n=1, busy=0 immediately with no clock edge. After release with int_req=1, a fresh full sequence is produced.
